sram_like_slave: RTL and testbench
==================================

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from the address handshake to data_ok; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port req, input, 1: initiator request valid.
REQ-006 SHALL have port wr, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port size, input, 2: 0 = byte, 1 = halfword, 2 = word; 3 is reserved.
REQ-008 SHALL have port addr, input, 32: byte address.
REQ-009 SHALL have port wdata, input, 32: write data, lane-aligned to the addressed bytes.
REQ-010 SHALL have port addr_ok, output, 1: address accepted this cycle.
REQ-011 SHALL have port data_ok, output, 1: transaction completes this cycle.
REQ-012 SHALL have port rdata, output, 32: read data; valid only while data_ok=1.
REQ-013 SHALL have port err_cnt, output, 8: saturating count of rejected misaligned or reserved-size requests.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, WAIT and RESP; exactly one transaction is outstanding at a time.
REQ-015 SHALL drive addr_ok = req & (state==IDLE) combinationally; addr_ok SHALL be 0 in WAIT and RESP.
REQ-016 On an address handshake (req & addr_ok) SHALL latch wr, size, addr[ADDR_W+1:0] and wdata, and load the latency counter with LATENCY-1.
REQ-017 On a handshake SHALL go to RESP when LATENCY==1, otherwise to WAIT.
REQ-018 In WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 0.
REQ-019 In RESP SHALL assert data_ok for exactly one cycle and then return to IDLE.
REQ-020 A new handshake SHALL NOT be accepted in the RESP cycle; the earliest next addr_ok is the cycle after data_ok, so back-to-back throughput is one transaction per LATENCY+1 cycles.
REQ-021 SHALL index the memory by word with addr[ADDR_W+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*2**ADDR_W.
REQ-022 Write byte enables SHALL be: size 0 -> 1 byte at addr[1:0]; size 1 -> bytes {addr[1],0}..+1; size 2 -> all 4 bytes.
REQ-023 A write SHALL update only the enabled byte lanes, taking them from the same lanes of the latched wdata, and SHALL commit in the RESP cycle.
REQ-024 A read SHALL return the full 32-bit word on rdata in the RESP cycle regardless of size; the initiator extracts the lanes.
REQ-025 A read issued after a write to the same word SHALL observe the written data.
REQ-026 Misaligned requests (size 1 with addr[0]=1; size 2 with addr[1:0]!=0) and size 3 SHALL still be accepted and SHALL complete with data_ok.
REQ-027 For such requests, a write SHALL be suppressed, a read SHALL return 32'h0, and err_cnt SHALL increment, saturating at 255.
REQ-028 req deasserting while the FSM is in WAIT or RESP SHALL NOT affect the outstanding transaction.
REQ-029 wr, size, addr and wdata changes after the handshake SHALL be ignored.
REQ-030 rdata SHALL be registered and SHALL hold its last value while data_ok=0.

Reset
REQ-031 While rst=0 the block SHALL force state=IDLE, counter=0, data_ok=0, rdata=0 and err_cnt=0 immediately, without waiting for a clock edge.
REQ-032 Asserting reset mid-transaction SHALL abort the transaction: no data_ok is issued and a pending write is not committed.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 addr_ok SHALL be 0 while rst=0.
REQ-035 The first handshake SHALL be possible on the first rising edge after rst returns to 1.

Verification
REQ-036 With LATENCY=2: write word 0xDEADBEEF to 0x10, then read 0x10 -> addr_ok at each request cycle, data_ok 2 cycles after each handshake, read rdata=0xDEADBEEF.
REQ-037 Byte write 0x000000AA to 0x13 (size 0) over 0x11223344, then read 0x10 -> rdata=0xAA223344.
REQ-038 Halfword write to 0x21 (misaligned), then read 0x20 -> write suppressed, err_cnt=1, read returns the old word; misaligned read of 0x22 (size 2) -> rdata=0, err_cnt=2.
REQ-039 req held high continuously with LATENCY=1 -> addr_ok and data_ok alternate, one transaction every 2 cycles, never two outstanding.
REQ-040 Reset asserted in the WAIT cycle of a write to 0x30 -> no data_ok is issued, the word at 0x30 is unchanged, and addr_ok is available on the first edge after release.
REQ-041 Access 0x10 and 0x10+4*2**ADDR_W -> both alias to the same word.

Source files
------------

// File: rtl/sram_like_slave.sv
// SRAM-like memory slave: one outstanding transaction, fixed response latency,
// byte/halfword/word writes with lane enables and a saturating error counter.
module sram_like_slave #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [7:0]  err_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BA_W  = ADDR_W + 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              hs;
  logic              wr_q;
  logic [BA_W-1:0]   addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              bad_q;
  logic [3:0]        be_c;
  logic              bad_c;
  logic              cur_wr;
  logic              cur_bad;
  logic [BA_W-1:0]   cur_addr;
  logic [ADDR_W-1:0] cur_idx;
  logic              unused_addr;
  logic [31:0]       mem [DEPTH];

  assign addr_ok = req & rst & (state == IDLE);
  assign hs      = addr_ok;
  assign data_ok = (state == RESP);

  // Bits above the memory window only alias; they carry no information here.
  assign unused_addr = ^addr[31:BA_W];

  // Live transaction fields: inputs during the handshake cycle, latched copies after.
  assign cur_wr   = (state == IDLE) ? wr : wr_q;
  assign cur_bad  = (state == IDLE) ? bad_c : bad_q;
  assign cur_addr = (state == IDLE) ? addr[BA_W-1:0] : addr_q;
  assign cur_idx  = cur_addr[BA_W-1:2];

  // Byte-lane enables and misalignment/reserved-size detection.
  always_comb begin
    be_c  = 4'b0000;
    bad_c = 1'b0;
    case (size)
      2'd0: be_c = 4'b0001 << addr[1:0];
      2'd1: begin
        if (addr[0]) bad_c = 1'b1;
        else         be_c  = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        if (addr[1:0] != 2'b00) bad_c = 1'b1;
        else                    be_c  = 4'b1111;
      end
      default: bad_c = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      IDLE: begin
        if (hs) begin
          cnt_d      = CNT_W'(LATENCY - 1);
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata   <= '0;
      err_cnt <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
      if (hs) begin
        wr_q    <= wr;
        addr_q  <= addr[BA_W-1:0];
        wdata_q <= wdata;
        be_q    <= be_c;
        bad_q   <= bad_c;
        if (bad_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
      // Read data is captured on entry to RESP so it is valid with data_ok.
      if ((next_state == RESP) && !cur_wr) begin
        rdata <= cur_bad ? 32'h0 : mem[cur_idx];
      end
    end
  end

  // Storage is never reset; a reset before RESP drops the pending write.
  always_ff @(posedge clk) begin
    if ((state == RESP) && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[addr_q[BA_W-1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: transaction-level model checked every cycle plus
// directed vectors with hand-computed results.
module tb_sram_like_slave;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [7:0]  err_cnt;

  logic        req1, wr1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1;
  logic        addr_ok1, data_ok1;
  logic [31:0] rdata1;
  logic [7:0]  err_cnt1;

  int vectors     = 0;
  int miscompares = 0;
  bit run         = 1'b1;

  sram_like_slave #(.ADDR_W(ADDR_W), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .err_cnt(err_cnt)
  );

  sram_like_slave #(.ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
    .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1),
    .err_cnt(err_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending request with a completion time stamp.
  bit          m_busy;
  int          m_cyc, m_done, m_err;
  bit          m_wr, m_bad;
  bit [1:0]    m_size;
  bit [31:0]   m_addr, m_wdata, m_rdata;
  bit [31:0]   m_mem [int];

  function automatic bit is_bad(input bit [1:0] s, input bit [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a % 32'd2 != 0) || (s == 2'd2 && a % 32'd4 != 0);
  endfunction

  function automatic int word_of(input bit [31:0] a);
    return int'((a / 32'd4) % (32'd1 << ADDR_W));
  endfunction

  function automatic bit [31:0] mem_get(input int w);
    return m_mem.exists(w) ? m_mem[w] : 32'h0;
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d,
                                      input bit [31:0] a, input bit [1:0] s);
    bit [31:0] r;
    int        lane0;
    bit        en;
    r     = old;
    lane0 = int'(a % 32'd4);
    for (int b = 0; b < 4; b++) begin
      en = (s == 2'd2) || (s == 2'd0 && b == lane0) || (s == 2'd1 && b / 2 == lane0 / 2);
      if (en) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy  = 1'b0;
      m_err   = 0;
      m_rdata = 32'h0;
    end else if (m_busy && m_cyc == m_done) begin
      if (m_wr && !m_bad) m_mem[word_of(m_addr)] = merge(mem_get(word_of(m_addr)), m_wdata, m_addr, m_size);
      m_busy = 1'b0;
    end else if (!m_busy && req) begin
      m_busy  = 1'b1;
      m_wr    = wr;
      m_size  = size;
      m_addr  = addr;
      m_wdata = wdata;
      m_bad   = is_bad(size, addr);
      m_done  = m_cyc + int'(LAT);
      if (m_bad && m_err < 255) m_err++;
    end
    m_cyc++;
    if (m_busy && m_cyc == m_done && !m_wr) m_rdata = m_bad ? 32'h0 : mem_get(word_of(m_addr));
  end

  always @(negedge clk) begin
    if (!rst) begin
      m_busy  = 1'b0;
      m_err   = 0;
      m_rdata = 32'h0;
    end
    if (run) begin
      check("addr_ok", 32'(addr_ok), 32'(rst && req && !m_busy));
      check("data_ok", 32'(data_ok), 32'(rst && m_busy && m_cyc == m_done));
      check("rdata", rdata, m_rdata);
      check("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  task automatic wait_resp(input string tag, input bit chk, input bit [31:0] exp);
    int n;
    @(posedge clk); #1;
    req   = 1'b0;
    wr    = 1'($urandom);
    size  = 2'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    n = 1;
    while (!data_ok && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    if (chk) check({tag, "_rdata"}, rdata, exp);
  endtask

  task automatic do_txn(input bit w, input bit [1:0] s, input bit [31:0] a, input bit [31:0] d,
                        input bit chk, input bit [31:0] exp, input string tag);
    @(posedge clk); #1;
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    #1 check({tag, "_addr_ok"}, 32'(addr_ok), 32'd1);
    wait_resp(tag, chk, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0; wdata = 32'h0;
    req1 = 1'b0; wr1 = 1'b0; size1 = 2'd0; addr1 = 32'h0; wdata1 = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", 32'(addr_ok), 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;

    do_txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "wr10");
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, "rd10");

    do_txn(1'b1, 2'd2, 32'h10, 32'h11223344, 1'b0, 32'h0, "wr10b");
    do_txn(1'b1, 2'd0, 32'h13, 32'hAAAAAAAA, 1'b0, 32'h0, "wrbyte13");
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'hAA223344, "rdbyte");

    do_txn(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, "wr20");
    do_txn(1'b1, 2'd1, 32'h21, 32'h12345678, 1'b0, 32'h0, "wrmis21");
    do_txn(1'b0, 2'd2, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, "rd20");
    check("err_after_mis_wr", 32'(err_cnt), 32'd1);
    do_txn(1'b0, 2'd2, 32'h22, 32'h0, 1'b1, 32'h0, "rdmis22");
    check("err_after_mis_rd", 32'(err_cnt), 32'd2);
    do_txn(1'b0, 2'd3, 32'h20, 32'h0, 1'b1, 32'h0, "rdsize3");
    check("err_after_size3", 32'(err_cnt), 32'd3);
    do_txn(1'b1, 2'd1, 32'h22, 32'hBEEF1234, 1'b0, 32'h0, "wrhw22");
    do_txn(1'b0, 2'd0, 32'h20, 32'h0, 1'b1, 32'hBEEFF00D, "rdhw");

    do_txn(1'b1, 2'd2, 32'h10 + 32'd4 * (32'd1 << ADDR_W), 32'h0BADF00D, 1'b0, 32'h0, "wralias");
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'h0BADF00D, "rdalias_lo");
    do_txn(1'b0, 2'd2, 32'h80001010, 32'h0, 1'b1, 32'h0BADF00D, "rdalias_hi");

    // Reset during the WAIT cycle of an overwrite of 0x30.
    do_txn(1'b1, 2'd2, 32'h30, 32'h01010101, 1'b0, 32'h0, "wr30");
    check("err_pre_rst", 32'(err_cnt), 32'd3);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_data_ok", 32'(data_ok), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    req = 1'b1;
    #1 check("midrst_addr_ok", 32'(addr_ok), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_data_ok", 32'(data_ok), 32'd0);
    end
    wr = 1'b0; size = 2'd2; addr = 32'h30; rst = 1'b1;
    #1 check("release_addr_ok", 32'(addr_ok), 32'd1);
    wait_resp("rd30", 1'b1, 32'h01010101);

    for (int i = 0; i < 256; i++) do_txn(1'b0, 2'd3, 32'h0, 32'h0, 1'b1, 32'h0, "sat");
    check("err_saturated", 32'(err_cnt), 32'd255);

    // LATENCY=1 instance with req held high: one transaction every two cycles.
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = 32'h40; wdata1 = 32'h5A5A0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("l1_addr_ok", 32'(addr_ok1), 32'(k % 2 == 0));
      check("l1_data_ok", 32'(data_ok1), 32'(k % 2 == 1));
      if (k == 5 || k == 7) check("l1_rdata", rdata1, 32'h5A5A0001);
      if (k == 3) wr1 = 1'b0;
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    check("l1_err_cnt", 32'(err_cnt1), 32'd0);

    @(posedge clk); #1;
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
